regfile_wb_arb: RTL and testbench
=================================

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter NREQ, default 3, number of writeback requesters (0=ALU, 1=MEM, 2=MUL).
REQ-002 Parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 Parameter DATA_W, default 16, register data width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 reqValid  input  NREQ  per-requester write request valid.
REQ-007 reqAddr  input  NREQ*ADDR_W  per-requester destination register, requester i at slice i.
REQ-008 reqData  input  NREQ*DATA_W  per-requester write data, requester i at slice i.
REQ-009 reqReady  output  NREQ  one-hot-or-zero grant; request i is accepted when reqValid[i] and reqReady[i] are both high in the same cycle.
REQ-010 freeze  input  1  pipeline hold; while high no request is accepted.
REQ-011 wr  output  1  register file write enable, registered.
REQ-012 wrAddr  output  ADDR_W  register file write address, registered.
REQ-013 wrData  output  DATA_W  register file write data, registered.
REQ-014 pend  output  2**ADDR_W  scoreboard; bit r is high while any requester has reqValid high with reqAddr==r, or while a write to r is held in the output register.

Function
REQ-015 reqReady is combinational from reqValid, freeze and the round-robin pointer; at most one bit is high per cycle.
REQ-016 With freeze low, the arbiter grants the first valid requester at or after the pointer, searching upward modulo NREQ.
REQ-017 After a grant to requester g, the pointer becomes (g+1) mod NREQ on the next edge; with no grant, the pointer holds.
REQ-018 An accepted request with reqAddr!=0 appears as wr=1, wrAddr=reqAddr, wrData=reqData exactly one cycle later (latency 1).
REQ-019 An accepted request with reqAddr==0 is acknowledged but dropped: wr stays 0 in the following cycle.
REQ-020 In any cycle with no accepted request, the next cycle has wr=0; wrAddr and wrData hold their previous values.
REQ-021 While freeze is high, reqReady is all-zero, the pointer holds, and wr is 0 in the following cycle.
REQ-022 A requester holding reqValid high continuously with freeze low is granted within NREQ cycles.
REQ-023 Two requesters targeting the same register in one cycle are serialized in round-robin order; the later-granted write is the final value.
REQ-024 A requester must keep reqAddr and reqData stable while reqValid is high and not yet accepted; the block is not required to tolerate violation.

Reset
REQ-025 While rst is low at a rising edge: wr=0, wrAddr=0, wrData=0, pointer=0, pend output-register contribution cleared.
REQ-026 While rst is low, reqReady is all-zero, so no request is accepted during the reset cycle.
REQ-027 A request pending when reset asserts mid-operation is neither written nor acknowledged; the requester re-presents it after reset.

Structure
REQ-028 NREQ, ADDR_W, DATA_W defaults and the requester index constants (REQ_ALU, REQ_MEM, REQ_MUL) reside in shared package cpu_pkg.
REQ-029 Round-robin selection is a sub-module rr_arbiter (inputs: request vector, pointer, enable; output: one-hot grant).
REQ-030 The output register stage and the pend scoreboard reside in regfile_wb_arb.

Verification
REQ-031 Reset: hold rst=0 for 2 cycles with all reqValid=1 -> reqReady=000, wr=0, wrAddr=0, wrData=0 throughout.
REQ-032 Single request: ALU valid, addr=5, data=16'h1234 -> reqReady=001 in the same cycle; next cycle wr=1, wrAddr=5, wrData=16'h1234.
REQ-033 Fairness: all three valid continuously from pointer=0 -> grants 001, 010, 100, 001 on consecutive cycles; wr=1 each following cycle.
REQ-034 R0 drop: MEM valid, addr=0, data=16'hFFFF -> reqReady=010; next cycle wr=0.
REQ-035 Freeze: all valid, freeze=1 for 3 cycles -> reqReady=000 and wr=0; pointer unchanged; first grant after release goes to the pre-freeze pointer.
REQ-036 Conflict and scoreboard: ALU addr=7 data=16'h00AA and MUL addr=7 data=16'h00BB, pointer=0 -> pend[7]=1 until the second write leaves the output register; final wrData sequence 16'h00AA then 16'h00BB.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: writeback arbiter sizing and requester indices.
// Imported by the writeback arbiter and its round-robin sub-module.
package cpu_pkg;

  localparam int WB_NREQ   = 3;
  localparam int WB_ADDR_W = 4;
  localparam int WB_DATA_W = 16;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_MUL = 2;

  // Pointer width stays at least 1 bit so a single-requester build still elaborates.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo NREQ. The grant is one-hot, or zero when disabled or idle.
module rr_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ  = WB_NREQ,
  parameter int PTR_W = ptr_width(WB_NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  gnt
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] req_hi;
  logic [NREQ-1:0] gnt_hi;
  logic [NREQ-1:0] gnt_lo;

  // Requesters at or above the pointer win first; otherwise wrap to the lowest.
  // x & -x isolates the lowest set bit of each candidate vector.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask[i] = (PTR_W'(i) >= ptr);
    end
    req_hi = req & mask;
    gnt_hi = req_hi & (-req_hi);
    gnt_lo = req & (-req);
    gnt    = '0;
    if (en) begin
      gnt = (|req_hi) ? gnt_hi : gnt_lo;
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter: round-robin selection among the execution
// units, one registered write port, and a pending-write scoreboard.
module regfile_wb_arb
  import cpu_pkg::*;
#(
  parameter int NREQ   = WB_NREQ,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        reqValid,
  input  logic [NREQ*ADDR_W-1:0] reqAddr,
  input  logic [NREQ*DATA_W-1:0] reqData,
  output logic [NREQ-1:0]        reqReady,
  input  logic                   freeze,
  output logic                   wr,
  output logic [ADDR_W-1:0]      wrAddr,
  output logic [DATA_W-1:0]      wrData,
  output logic [2**ADDR_W-1:0]   pend
);

  localparam int PTR_W = ptr_width(NREQ);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              arb_en;
  logic [NREQ-1:0]   gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [2**ADDR_W-1:0] pend_vec;

  // Nothing is granted during reset or a pipeline hold.
  assign arb_en = rst && !freeze;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (reqValid),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign reqReady = gnt;

  always_comb begin
    ptr_d     = ptr_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    gnt_idx   = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        sel_addr = reqAddr[i*ADDR_W +: ADDR_W];
        sel_data = reqData[i*DATA_W +: DATA_W];
      end
    end
    if (|gnt) begin
      ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      // Register 0 is hardwired: acknowledge the request but never write it.
      if (sel_addr != '0) begin
        wr_d      = 1'b1;
        wr_addr_d = sel_addr;
        wr_data_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q     <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // A register is pending while any unit is still asking to write it or the
  // write sits in the output stage and has not reached the file yet.
  always_comb begin
    pend_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (reqValid[i]) begin
        pend_vec[reqAddr[i*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    if (wr_q) begin
      pend_vec[wr_addr_q] = 1'b1;
    end
  end

  assign pend   = pend_vec;
  assign wr     = wr_q;
  assign wrAddr = wr_addr_q;
  assign wrData = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: grants are checked as stimulus is applied,
// expected writes go into a queue that a negedge monitor drains.
module tb_regfile_wb_arb;
  import cpu_pkg::*;

  localparam int NREQ   = WB_NREQ;
  localparam int ADDR_W = WB_ADDR_W;
  localparam int DATA_W = WB_DATA_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req_valid = 3'b111;
  logic [NREQ*ADDR_W-1:0] req_addr = {4'd3, 4'd2, 4'd1};
  logic [NREQ*DATA_W-1:0] req_data = {16'h3333, 16'h2222, 16'h1111};
  logic [NREQ-1:0]        req_ready;
  logic                   freeze = 1'b0;
  logic                   wr;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [2**ADDR_W-1:0]   pend;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                due;
  } wr_exp_t;

  wr_exp_t exp_q[$];

  regfile_wb_arb dut (
    .clk      (clk),
    .rst      (rst),
    .reqValid (req_valid),
    .reqAddr  (req_addr),
    .reqData  (req_data),
    .reqReady (req_ready),
    .freeze   (freeze),
    .wr       (wr),
    .wrAddr   (wr_addr),
    .wrData   (wr_data),
    .pend     (pend)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the expected grant is hand-computed by the caller.
  task automatic applyStimulus(input logic rstn, input logic frz, input logic [NREQ-1:0] v,
                               input logic [NREQ*ADDR_W-1:0] a, input logic [NREQ*DATA_W-1:0] d,
                               input logic [NREQ-1:0] exp_ready);
    wr_exp_t e;
    @(negedge clk);
    rst       = rstn;
    freeze    = frz;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    #1;
    checkOutput("reqReady", req_ready, exp_ready);
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ready[i] && a[i*ADDR_W +: ADDR_W] != '0) begin
        e.addr = a[i*ADDR_W +: ADDR_W];
        e.data = d[i*DATA_W +: DATA_W];
        e.due  = cyc + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: every write must match the queue head in the cycle it is due.
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("wr_spurious", wr, 1'b0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wrAddr", wr_addr, e.addr);
          checkOutput("wrData", wr_data, e.data);
          checkOutput("wr_latency", cyc, e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        checkOutput("wr_missing", wr, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for two cycles with every requester asking.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 3'b000);
      checkOutput("rst_wr", wr, 1'b0);
      checkOutput("rst_wrAddr", wr_addr, 4'd0);
      checkOutput("rst_wrData", wr_data, 16'h0000);
    end

    applyStimulus(1'b1, 1'b0, 3'b001, {4'd0, 4'd0, 4'd5}, {16'h0, 16'h0, 16'h1234}, 3'b001);
    // Register-0 write from MEM: acknowledged, never written.
    applyStimulus(1'b1, 1'b0, 3'b010, {4'd0, 4'd0, 4'd0}, {16'h0, 16'hFFFF, 16'h0}, 3'b010);
    applyStimulus(1'b1, 1'b0, 3'b100, {4'd3, 4'd0, 4'd0}, {16'h3333, 16'h0, 16'h0}, 3'b100);
    checkOutput("drop_wr", wr, 1'b0);
    checkOutput("hold_wrAddr", wr_addr, 4'd5);
    checkOutput("hold_wrData", wr_data, 16'h1234);

    // Fairness from pointer 0; unaccepted requesters keep their data stable.
    applyStimulus(1'b1, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3000, 16'h2000, 16'h1001}, 3'b001);
    applyStimulus(1'b1, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3000, 16'h2000, 16'h1002}, 3'b010);
    applyStimulus(1'b1, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3000, 16'h2001, 16'h1002}, 3'b100);
    applyStimulus(1'b1, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3001, 16'h2001, 16'h1002}, 3'b001);

    // Freeze three cycles; pointer stays at MEM.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3001, 16'h2001, 16'h1003}, 3'b000);
      if (k > 0) checkOutput("freeze_wr", wr, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3001, 16'h2001, 16'h1003}, 3'b010);
    checkOutput("freeze_last_wr", wr, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b100, {4'd4, 4'd0, 4'd0}, {16'h4444, 16'h0, 16'h0}, 3'b100);

    // Same-register conflict from pointer 0 and the pend scoreboard.
    applyStimulus(1'b1, 1'b0, 3'b101, {4'd7, 4'd0, 4'd7}, {16'h00BB, 16'h0, 16'h00AA}, 3'b001);
    checkOutput("pend7_req", pend[7], 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b100, {4'd7, 4'd0, 4'd0}, {16'h00BB, 16'h0, 16'h0}, 3'b100);
    checkOutput("pend7_mul", pend[7], 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b000, {4'd0, 4'd0, 4'd0}, {16'h0, 16'h0, 16'h0}, 3'b000);
    checkOutput("pend_outreg", pend, 16'h0080);
    applyStimulus(1'b1, 1'b0, 3'b000, {4'd0, 4'd0, 4'd0}, {16'h0, 16'h0, 16'h0}, 3'b000);
    checkOutput("pend_clear", pend, 16'h0000);
    checkOutput("final_wrData", wr_data, 16'h00BB);

    // Reset mid-operation drops the pending request; it is re-presented after.
    applyStimulus(1'b0, 1'b0, 3'b001, {4'd0, 4'd0, 4'd9}, {16'h0, 16'h0, 16'h9999}, 3'b000);
    applyStimulus(1'b0, 1'b0, 3'b001, {4'd0, 4'd0, 4'd9}, {16'h0, 16'h0, 16'h9999}, 3'b000);
    checkOutput("midrst_wr", wr, 1'b0);
    checkOutput("midrst_wrAddr", wr_addr, 4'd0);
    checkOutput("midrst_wrData", wr_data, 16'h0000);
    applyStimulus(1'b1, 1'b0, 3'b001, {4'd0, 4'd0, 4'd9}, {16'h0, 16'h0, 16'h9999}, 3'b001);
    applyStimulus(1'b1, 1'b0, 3'b000, {4'd0, 4'd0, 4'd0}, {16'h0, 16'h0, 16'h0}, 3'b000);
    applyStimulus(1'b1, 1'b0, 3'b000, {4'd0, 4'd0, 4'd0}, {16'h0, 16'h0, 16'h0}, 3'b000);

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
